// File: rtl/fml_sram_pkg.sv
// Shared definitions for the FML SRAM responder: burst geometry, FSM
// encodings and the in-line burst offset helper.
package fml_sram_pkg;

    localparam int FML_BURST_LEN = 8;
    localparam int FML_OFS_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ACCESS = 3'd1,
        ST_RD_BURST  = 3'd2,
        ST_WR_BURST  = 3'd3,
        ST_WR_ACCESS = 3'd4
    } state_t;

    // Word offset inside the 16-byte line; wraps modulo the burst length.
    function automatic logic [FML_OFS_W-1:0] burst_ofs(input logic [FML_OFS_W-1:0] start,
                                                       input logic [FML_OFS_W-1:0] k);
        return start + k;
    endfunction

endpackage

// File: rtl/fml_sram_linebuf.sv
// One burst line: 8 entries of {sel[1:0], data[15:0]}, one synchronous write
// port and one combinational read port.
module fml_sram_linebuf
    import fml_sram_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [FML_OFS_W-1:0] wr_idx,
    input  logic [17:0]          wr_data,
    input  logic [FML_OFS_W-1:0] rd_idx,
    output logic [17:0]          rd_data
);

    logic [17:0] mem [FML_BURST_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fml_sram.sv
// FML 8x16 responder for an asynchronous 16-bit SRAM. Whole bursts are
// buffered so the SRAM runs at wait-state pace and FML data is 8 back-to-back cycles.
module fml_sram
    import fml_sram_pkg::*;
#(
    parameter int fml_depth   = 19,
    parameter int wait_states = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    input  logic                 fml_we,
    output logic                 fml_ack,
    input  logic [1:0]           fml_sel,
    input  logic [15:0]          fml_di,
    output logic [15:0]          fml_do,
    output logic [fml_depth-2:0] sram_adr,
    input  logic [15:0]          sram_dq_i,
    output logic [15:0]          sram_dq_o,
    output logic                 sram_dq_oe,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n
);

    localparam logic [3:0]           WS_RD  = 4'(wait_states);
    localparam logic [3:0]           WS_WR  = 4'(wait_states + 1);
    localparam logic [FML_OFS_W-1:0] LAST_K = FML_OFS_W'(FML_BURST_LEN - 1);

    state_t                 state;
    logic [FML_OFS_W-1:0]   k;
    logic [FML_OFS_W-1:0]   k_inc;
    logic [3:0]             wcnt;
    logic [fml_depth-5:0]   base_q;
    logic [FML_OFS_W-1:0]   ofs_q;

    logic                   lb_we;
    logic [17:0]            lb_wdata;
    logic [FML_OFS_W-1:0]   rd_idx;
    logic [17:0]            lb_rd;
    logic                   load_wr;
    logic                   unused;

    assign unused = fml_adr[0];
    assign k_inc  = k + 1'b1;

    // Read port always points at the word the next edge will need.
    assign rd_idx   = (state == ST_RD_BURST || state == ST_WR_ACCESS) ? k_inc : '0;
    assign lb_we    = (state == ST_WR_BURST) || (state == ST_RD_ACCESS && wcnt == 4'd0);
    assign lb_wdata = (state == ST_WR_BURST) ? {fml_sel, fml_di} : {2'b11, sram_dq_i};
    assign load_wr  = (state == ST_WR_BURST && k == LAST_K)
                   || (state == ST_WR_ACCESS && wcnt == 4'd0 && k != LAST_K);

    function automatic logic [fml_depth-2:0] word_adr(input logic [FML_OFS_W-1:0] idx);
        return {base_q, burst_ofs(ofs_q, idx)};
    endfunction

    fml_sram_linebuf u_linebuf (
        .clk     (sys_clk),
        .we      (lb_we),
        .wr_idx  (k),
        .wr_data (lb_wdata),
        .rd_idx  (rd_idx),
        .rd_data (lb_rd)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            wcnt       <= '0;
            base_q     <= '0;
            ofs_q      <= '0;
            fml_ack    <= 1'b0;
            fml_do     <= '0;
            sram_adr   <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            fml_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    base_q <= fml_adr[fml_depth-1:4];
                    ofs_q  <= fml_adr[3:1];
                    k      <= '0;
                    if (fml_stb) begin
                        if (fml_we) begin
                            state   <= ST_WR_BURST;
                            fml_ack <= 1'b1;
                        end else begin
                            state     <= ST_RD_ACCESS;
                            sram_adr  <= fml_adr[fml_depth-1:1];
                            wcnt      <= WS_RD;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end
                    end
                end
                ST_RD_ACCESS: begin
                    if (wcnt == 4'd0) begin
                        if (k == LAST_K) begin
                            state     <= ST_RD_BURST;
                            k         <= '0;
                            fml_ack   <= 1'b1;
                            fml_do    <= lb_rd[15:0];
                            sram_ce_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_ub_n <= 1'b1;
                            sram_lb_n <= 1'b1;
                        end else begin
                            k        <= k_inc;
                            sram_adr <= word_adr(k_inc);
                            wcnt     <= WS_RD;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_RD_BURST: begin
                    if (k == LAST_K) begin
                        state  <= ST_IDLE;
                        k      <= '0;
                        fml_do <= '0;
                    end else begin
                        k      <= k_inc;
                        fml_do <= lb_rd[15:0];
                    end
                end
                ST_WR_BURST: begin
                    if (k == LAST_K) begin
                        state <= ST_WR_ACCESS;
                        k     <= '0;
                    end else begin
                        k <= k_inc;
                    end
                end
                ST_WR_ACCESS: begin
                    if (wcnt == 4'd0) begin
                        if (k == LAST_K) begin
                            state      <= ST_IDLE;
                            k          <= '0;
                            sram_dq_oe <= 1'b0;
                            sram_ce_n  <= 1'b1;
                            sram_we_n  <= 1'b1;
                            sram_ub_n  <= 1'b1;
                            sram_lb_n  <= 1'b1;
                        end else begin
                            k <= k_inc;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                        // Last cycle of each slot keeps we_n high for hold/recovery.
                        if (wcnt == 4'd1) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Set up the next SRAM write slot from the line buffer.
            if (load_wr) begin
                sram_adr   <= word_adr(rd_idx);
                sram_dq_o  <= lb_rd[15:0];
                sram_dq_oe <= 1'b1;
                sram_ce_n  <= 1'b0;
                sram_oe_n  <= 1'b1;
                sram_we_n  <= ~|lb_rd[17:16];
                sram_ub_n  <= ~lb_rd[17];
                sram_lb_n  <= ~lb_rd[16];
                wcnt       <= WS_WR;
            end
        end
    end

endmodule

// File: tb/tb_fml_sram.sv
// Directed bench for fml_sram: table of read vectors plus hand-written write,
// write-then-read, mid-burst reset and 3-wait-state sequences.
module tb_fml_sram;

    typedef struct packed {
        logic [18:0]      adr;
        logic [7:0]       ack;
        logic [7:0][15:0] dat;
        logic [7:0][7:0]  sadr;
    } rd_vec_t;

    logic        sys_clk;
    logic        sys_rst;
    logic [18:0] fml_adr;
    logic        stb;
    logic        sel_inst;
    logic        fml_we;
    logic [1:0]  fml_sel;
    logic [15:0] fml_di;

    logic        stb1, ack1, dq_oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
    logic [15:0] do1, dq_i1, dq_o1;
    logic [17:0] adr1;
    logic        stb3, ack3, dq_oe3, ce_n3, oe_n3, we_n3, ub_n3, lb_n3;
    logic [15:0] do3, dq_i3, dq_o3;
    logic [17:0] adr3;

    logic        obs_ack, obs_ce_n, obs_oe_n;
    logic [15:0] obs_do;
    logic [17:0] obs_adr;

    logic [15:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_a;
    logic [15:0] pre_d;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int conflict_cnt = 0;

    assign stb1 = stb & ~sel_inst;
    assign stb3 = stb & sel_inst;
    assign obs_ack  = sel_inst ? ack3  : ack1;
    assign obs_ce_n = sel_inst ? ce_n3 : ce_n1;
    assign obs_oe_n = sel_inst ? oe_n3 : oe_n1;
    assign obs_do   = sel_inst ? do3   : do1;
    assign obs_adr  = sel_inst ? adr3  : adr1;

    assign dq_i1 = (!ce_n1 && !oe_n1) ? mem[adr1[7:0]] : 16'hDEAD;
    assign dq_i3 = (!ce_n3 && !oe_n3) ? mem[adr3[7:0]] : 16'hDEAD;

    fml_sram #(.fml_depth(19), .wait_states(1)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fml_adr(fml_adr), .fml_stb(stb1),
        .fml_we(fml_we), .fml_ack(ack1), .fml_sel(fml_sel), .fml_di(fml_di),
        .fml_do(do1), .sram_adr(adr1), .sram_dq_i(dq_i1), .sram_dq_o(dq_o1),
        .sram_dq_oe(dq_oe1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1),
        .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    fml_sram #(.fml_depth(19), .wait_states(3)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fml_adr(fml_adr), .fml_stb(stb3),
        .fml_we(1'b0), .fml_ack(ack3), .fml_sel(fml_sel), .fml_di(fml_di),
        .fml_do(do3), .sram_adr(adr3), .sram_dq_i(dq_i3), .sram_dq_o(dq_o3),
        .sram_dq_oe(dq_oe3), .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3),
        .sram_ub_n(ub_n3), .sram_lb_n(lb_n3)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // SRAM model: byte-lane writes from the ws=1 instance, plus bench preload.
    always @(posedge sys_clk) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (!ce_n1 && !we_n1) begin
            if (!ub_n1) mem[adr1[7:0]][15:8] <= dq_o1[15:8];
            if (!lb_n1) mem[adr1[7:0]][7:0]  <= dq_o1[7:0];
        end
    end

    always @(posedge sys_clk) begin
        if (ack1) ack_cnt <= ack_cnt + 1;
    end

    always @(negedge sys_clk) begin
        if (dq_oe1 && !oe_n1) conflict_cnt <= conflict_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic preset(input logic [7:0] a, input logic [15:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(negedge sys_clk);
        pre_en = 1'b0;
    endtask

    // Called mid-cycle (negedge); that cycle is cycle 0. Returns mid-cycle at ack+8.
    task automatic do_read(input logic [18:0] adr, input logic inst, input int ws,
                           output int ack_cyc, output logic [7:0][15:0] dat,
                           output logic [7:0][7:0] sadr, output int err);
        int  per;
        bit  done;
        per     = ws + 1;
        done    = 1'b0;
        ack_cyc = -1;
        err     = 0;
        dat     = '0;
        sadr    = '0;
        sel_inst = inst;
        fml_adr  = adr;
        fml_we   = 1'b0;
        stb      = 1'b1;
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge sys_clk);
            if (c <= 8 * per) begin
                if (obs_ce_n || obs_oe_n) err++;
                if ((c - 1) % per == 0) sadr[(c - 1) / per] = obs_adr[7:0];
                else if (obs_adr[7:0] != sadr[(c - 1) / per]) err++;
            end
            if (obs_ack) begin
                if (ack_cyc < 0) ack_cyc = c;
                else err++;
                stb = 1'b0;
            end
            if (ack_cyc >= 0 && c - ack_cyc < 8) dat[c - ack_cyc] = obs_do;
            if (ack_cyc >= 0 && c - ack_cyc == 8) begin
                if (obs_do != 16'h0 || !obs_ce_n) err++;
                done = 1'b1;
            end
        end
        stb      = 1'b0;
        sel_inst = 1'b0;
    endtask

    // ws=1 instance only; returns mid-cycle at cycle 33.
    task automatic do_write(input logic [18:0] adr, input logic [7:0][15:0] wdat,
                            input logic [15:0] sel, output int ack_cyc,
                            output int we_lo, output int oe_cyc, output int err);
        ack_cyc = -1;
        we_lo   = 0;
        oe_cyc  = 0;
        err     = 0;
        sel_inst = 1'b0;
        fml_adr  = adr;
        fml_we   = 1'b1;
        stb      = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge sys_clk);
            if (ack1) begin
                if (ack_cyc < 0) ack_cyc = c;
                else err++;
                stb = 1'b0;
            end
            if (c <= 8) begin
                fml_di  = wdat[c - 1];
                fml_sel = sel[2 * (c - 1) +: 2];
            end
            if (!we_n1) we_lo++;
            if (dq_oe1) oe_cyc++;
            if (c == 33 && (dq_oe1 || !we_n1 || !ce_n1)) err++;
        end
        stb    = 1'b0;
        fml_we = 1'b0;
    endtask

    rd_vec_t          rv [3];
    int               ack_c, e, we_lo, oe_c, exp_acks;
    logic [7:0][15:0] got_d;
    logic [7:0][7:0]  got_a;
    logic [7:0][15:0] wdat;
    logic [7:0][15:0] exp_d;
    logic [7:0][7:0]  exp_a;

    initial begin
        rv[0] = '{adr: 19'h00010, ack: 8'd17,
                  dat: {16'hA00F, 16'hA00E, 16'hA00D, 16'hA00C, 16'hA00B, 16'hA00A, 16'hA009, 16'hA008},
                  sadr: {8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08}};
        rv[1] = '{adr: 19'h0001A, ack: 8'd17,
                  dat: {16'hA00C, 16'hA00B, 16'hA00A, 16'hA009, 16'hA008, 16'hA00F, 16'hA00E, 16'hA00D},
                  sadr: {8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08, 8'h0F, 8'h0E, 8'h0D}};
        rv[2] = '{adr: 19'h0001F, ack: 8'd17,
                  dat: {16'hA00E, 16'hA00D, 16'hA00C, 16'hA00B, 16'hA00A, 16'hA009, 16'hA008, 16'hA00F},
                  sadr: {8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08, 8'h0F}};

        sys_rst  = 1'b1;
        stb      = 1'b0;
        sel_inst = 1'b0;
        fml_adr  = '0;
        fml_we   = 1'b0;
        fml_sel  = 2'b00;
        fml_di   = '0;
        pre_en   = 1'b0;
        pre_a    = '0;
        pre_d    = '0;
        exp_acks = 0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            preset(8'(8'h08 + i), 16'(16'hA008 + i));
            preset(8'(8'h10 + i), 16'(16'hEE10 + i));
            preset(8'(8'h20 + i), 16'(16'hC020 + i));
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);

        chk("rst_ack", {31'd0, ack1}, 32'd0);
        chk("rst_do", {16'd0, do1}, 32'd0);
        chk("rst_adr", {14'd0, adr1}, 32'd0);
        chk("rst_dq", {15'd0, dq_o1, dq_oe1}, 32'd0);
        chk("rst_strobes", {27'd0, ce_n1, oe_n1, we_n1, ub_n1, lb_n1}, 32'h1F);

        for (int i = 0; i < 3; i++) begin
            do_read(rv[i].adr, 1'b0, 1, ack_c, got_d, got_a, e);
            exp_acks++;
            chk($sformatf("rd%0d_ack_cycle", i), ack_c, {24'd0, rv[i].ack});
            chk($sformatf("rd%0d_protocol", i), e, 0);
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("rd%0d_do%0d", i, j), {16'd0, got_d[j]}, {16'd0, rv[i].dat[j]});
                chk($sformatf("rd%0d_sadr%0d", i, j), {24'd0, got_a[j]}, {24'd0, rv[i].sadr[j]});
            end
            @(negedge sys_clk);
        end

        // Eviction with word 3 low byte only, then immediate refill of the same line.
        wdat = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
        exp_d = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'hEE33, 16'h2222, 16'h1111, 16'h0000};
        do_write(19'h00020, wdat, 16'hFF7F, ack_c, we_lo, oe_c, e);
        exp_acks++;
        chk("wr_ack_cycle", ack_c, 1);
        chk("wr_protocol", e, 0);
        chk("wr_we_low_cycles", we_lo, 16);
        chk("wr_dq_oe_cycles", oe_c, 24);
        for (int j = 0; j < 8; j++)
            chk($sformatf("wr_mem%0d", j), {16'd0, mem[8'h10 + j]}, {16'd0, exp_d[j]});

        do_read(19'h00020, 1'b0, 1, ack_c, got_d, got_a, e);
        exp_acks++;
        chk("wr2rd_ack_cycle", ack_c, 17);
        chk("wr2rd_protocol", e, 0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("wr2rd_do%0d", j), {16'd0, got_d[j]}, {16'd0, exp_d[j]});
        chk("oe_conflicts", conflict_cnt, 0);
        chk("ack_count_a", ack_cnt, exp_acks);

        // Reset taken at the boundary into WR_ACCESS word 4.
        @(negedge sys_clk);
        fml_adr = 19'h00040;
        fml_we  = 1'b1;
        stb     = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sys_clk);
            if (c == 1) begin
                chk("rstmid_ack", {31'd0, ack1}, 32'd1);
                stb = 1'b0;
            end
            if (c <= 8) begin
                fml_di  = 16'(16'h5A00 + c - 1);
                fml_sel = 2'b11;
            end
        end
        exp_acks++;
        chk("rstmid_busy", {14'd0, adr1[7:0], 7'd0, dq_oe1, 2'd0}, {14'd0, 8'h23, 7'd0, 1'b1, 2'd0});
        fml_we  = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rstmid_outs", {ack1, do1, dq_oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1},
            {1'b0, 16'h0000, 1'b0, 5'h1F});
        chk("rstmid_adr_dq", {adr1[15:0], dq_o1}, 32'd0);
        repeat (4) @(negedge sys_clk);
        chk("ack_count_b", ack_cnt, exp_acks);
        exp_d = {16'hC027, 16'hC026, 16'hC025, 16'hC024, 16'h5A03, 16'h5A02, 16'h5A01, 16'h5A00};
        for (int j = 0; j < 8; j++)
            chk($sformatf("rstmid_mem%0d", j), {16'd0, mem[8'h20 + j]}, {16'd0, exp_d[j]});

        do_read(19'h00040, 1'b0, 1, ack_c, got_d, got_a, e);
        exp_acks++;
        chk("postrst_ack_cycle", ack_c, 17);
        chk("postrst_protocol", e, 0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("postrst_do%0d", j), {16'd0, got_d[j]}, {16'd0, exp_d[j]});

        // wait_states = 3 instance.
        @(negedge sys_clk);
        do_read(19'h00010, 1'b1, 3, ack_c, got_d, got_a, e);
        chk("ws3_ack_cycle", ack_c, 33);
        chk("ws3_protocol", e, 0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("ws3_do%0d", j), {16'd0, got_d[j]}, {16'd0, rv[0].dat[j]});
            chk($sformatf("ws3_sadr%0d", j), {24'd0, got_a[j]}, {24'd0, rv[0].sadr[j]});
        end
        chk("ack_count_c", ack_cnt, exp_acks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
